// File: rtl/ulpb_tx_arb4_pkg.sv
// ulpb_tx_arb4_pkg: shared state encodings and sizes for the 4-way TX arbiter
package ulpb_tx_arb4_pkg;
  localparam int NUM_REQ = 4;
  localparam int PTR_W = 2;
  typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_WAIT_RESP, ARB_RESP} arb_state_e;
endpackage

// File: rtl/ulpb_tx_arb4_rr_pick4.sv
// ulpb_rr_pick4: one-hot pick of the first set request at or after ptr, wrapping 3 -> 0
module ulpb_rr_pick4 import ulpb_tx_arb4_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);
  logic [NUM_REQ-1:0] rot, sel;
  always_comb begin
    rot = (req >> ptr) | (req << (3'd4 - {1'b0, ptr}));
    sel = rot & (~rot + 1'b1);
    pick = (sel << ptr) | (sel >> (3'd4 - {1'b0, ptr}));
  end
endmodule

// File: rtl/ulpb_tx_arb4.sv
// ulpb_tx_arb4: 4-requester arbiter for a bus node TX port; ULPB_TX_ARB_FIXED_PRIO_EN selects fixed priority
module ulpb_tx_arb4 import ulpb_tx_arb4_pkg::*; #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*ADDR_WIDTH-1:0] REQ_TX_ADDR,
  input  logic [4*DATA_WIDTH-1:0] REQ_TX_DATA,
  input  logic [3:0]              REQ_TX_PEND,
  input  logic [3:0]              REQ_TX_REQ,
  output logic [3:0]              REQ_TX_ACK,
  output logic [3:0]              REQ_TX_SUCC,
  output logic [3:0]              REQ_TX_FAIL,
  input  logic [3:0]              REQ_TX_RESP_ACK,
  output logic [ADDR_WIDTH-1:0]   TX_ADDR,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_PEND,
  output logic                    TX_REQ,
  input  logic                    TX_ACK,
  input  logic                    TX_SUCC,
  input  logic                    TX_FAIL,
  output logic                    TX_RESP_ACK,
  output logic [3:0]              GRANT
);
  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick;
  logic [PTR_W-1:0] g, ptr;
  logic succ_q, succ_d, fail_q, fail_d, word_seen_q, word_seen_d, resp_ack_q, resp_ack_d, ack_prev_q;
  logic active, ack_rise, resp_done;
  assign g = {grant_q[3] | grant_q[2], grant_q[3] | grant_q[1]};
  assign active = state_q == ARB_XFER || state_q == ARB_WAIT_RESP;
  assign ack_rise = TX_ACK & ~ack_prev_q;
  assign resp_done = state_q == ARB_RESP && REQ_TX_RESP_ACK[g];
  assign TX_ADDR = active ? REQ_TX_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign TX_DATA = active ? REQ_TX_DATA[g*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign TX_PEND = active & REQ_TX_PEND[g];
  assign TX_REQ = active & REQ_TX_REQ[g];
  assign REQ_TX_ACK = active && TX_ACK ? grant_q : '0;
  assign REQ_TX_SUCC = succ_q ? grant_q : '0;
  assign REQ_TX_FAIL = fail_q ? grant_q : '0;
  assign TX_RESP_ACK = resp_ack_q;
  assign GRANT = grant_q;
  ulpb_rr_pick4 u_pick (.req(REQ_TX_REQ), .ptr(ptr), .pick(pick));
`ifdef ULPB_TX_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;
  assign ptr_d = resp_done ? g + 2'd1 : ptr_q;
  assign ptr = ptr_q;
  always_ff @(posedge CLK) ptr_q <= RESET ? '0 : ptr_d;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    succ_d = succ_q;
    fail_d = fail_q;
    word_seen_d = word_seen_q;
    resp_ack_d = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (|REQ_TX_REQ) begin
        grant_d = pick;
        state_d = ARB_XFER;
      end
    end else if (active && (TX_SUCC || TX_FAIL)) begin
      succ_d = TX_SUCC & ~TX_FAIL;
      fail_d = TX_FAIL;
      resp_ack_d = 1'b1;
      state_d = ARB_RESP;
    end else if (state_q == ARB_XFER && ack_rise) begin
      word_seen_d = 1'b1;
      state_d = TX_PEND ? ARB_XFER : ARB_WAIT_RESP;
    end else if (state_q == ARB_XFER && !word_seen_q && !REQ_TX_REQ[g]) begin
      grant_d = '0;
      state_d = ARB_IDLE;
    end else if (resp_done) begin
      grant_d = '0;
      succ_d = 1'b0;
      fail_d = 1'b0;
      word_seen_d = 1'b0;
      state_d = ARB_IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      succ_q <= 1'b0;
      fail_q <= 1'b0;
      word_seen_q <= 1'b0;
      resp_ack_q <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      succ_q <= succ_d;
      fail_q <= fail_d;
      word_seen_q <= word_seen_d;
      resp_ack_q <= resp_ack_d;
      ack_prev_q <= TX_ACK;
    end
  end
endmodule

// File: tb/tb_ulpb_tx_arb4.sv
// tb_ulpb_tx_arb4: directed self-checking bench for ulpb_tx_arb4
module tb_ulpb_tx_arb4;
  logic CLK = 1'b0, RESET = 1'b1;
  logic [31:0] req_addr;
  logic [127:0] req_data;
  logic [3:0] req_pend, req_req, req_ack, req_succ, req_fail, req_resp_ack, grant;
  logic [7:0] tx_addr;
  logic [31:0] tx_data;
  logic tx_pend, tx_req, tx_ack, tx_succ, tx_fail, tx_resp_ack;
  int chk = 0, err = 0;
`ifdef ULPB_TX_ARB_FIXED_PRIO_EN
  localparam logic [3:0] EXP_1001_PTR3 = 4'b0001, EXP_SECOND = 4'b0001;
`else
  localparam logic [3:0] EXP_1001_PTR3 = 4'b1000, EXP_SECOND = 4'b1000;
`endif

  ulpb_tx_arb4 dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_TX_ADDR(req_addr), .REQ_TX_DATA(req_data), .REQ_TX_PEND(req_pend), .REQ_TX_REQ(req_req),
    .REQ_TX_ACK(req_ack), .REQ_TX_SUCC(req_succ), .REQ_TX_FAIL(req_fail), .REQ_TX_RESP_ACK(req_resp_ack),
    .TX_ADDR(tx_addr), .TX_DATA(tx_data), .TX_PEND(tx_pend), .TX_REQ(tx_req),
    .TX_ACK(tx_ack), .TX_SUCC(tx_succ), .TX_FAIL(tx_fail), .TX_RESP_ACK(tx_resp_ack), .GRANT(grant)
  );

  always #5 CLK = ~CLK;

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic finish_msg(input logic [3:0] g);
    tx_succ = 1'b1;
    cyc();
    tx_succ = 1'b0;
    req_req = req_req & ~g;
    req_resp_ack = g;
    cyc();
    req_resp_ack = '0;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    cyc();
    cyc();
    chk++; if (grant !== 4'b0000) begin err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    chk++; if (tx_req !== 1'b0 || tx_resp_ack !== 1'b0) begin err++; $display("FAIL reset_tx: got req=%b resp_ack=%b want 0 0", tx_req, tx_resp_ack); end
    chk++; if ({req_ack, req_succ, req_fail} !== 12'h000) begin err++; $display("FAIL reset_req_outs: got %h want 000", {req_ack, req_succ, req_fail}); end
    RESET = 1'b0;
    cyc();
  endtask

  task automatic test_rr_pair;
    req_req = 4'b1010;
    cyc();
    chk++; if (grant !== 4'b0010) begin err++; $display("FAIL rr_first_grant: got %b want 0010", grant); end
    chk++; if (tx_req !== 1'b1 || tx_addr !== 8'h11) begin err++; $display("FAIL rr_mux: got req=%b addr=%h want 1 11", tx_req, tx_addr); end
    tx_ack = 1'b1;
    #1;
    chk++; if (req_ack !== 4'b0010) begin err++; $display("FAIL rr_ack_route: got %b want 0010", req_ack); end
    cyc();
    tx_ack = 1'b0;
    req_req[1] = 1'b0;
    tx_succ = 1'b1;
    cyc();
    tx_succ = 1'b0;
    #1;
    chk++; if (tx_resp_ack !== 1'b1 || req_succ !== 4'b0010) begin err++; $display("FAIL rr_resp: got resp_ack=%b succ=%b want 1 0010", tx_resp_ack, req_succ); end
    req_resp_ack = 4'b0010;
    cyc();
    req_resp_ack = '0;
    chk++; if (grant !== 4'b0000 || req_succ !== 4'b0000) begin err++; $display("FAIL rr_release: got grant=%b succ=%b want 0000 0000", grant, req_succ); end
    cyc();
    chk++; if (grant !== 4'b1000) begin err++; $display("FAIL rr_second_grant: got %b want 1000", grant); end
    finish_msg(4'b1000);
  endtask

  task automatic test_multiword;
    req_req = 4'b0100;
    cyc();
    chk++; if (grant !== 4'b0100) begin err++; $display("FAIL mw_grant: got %b want 0100", grant); end
    req_req = 4'b0101;
    for (int w = 0; w < 3; w++) begin
      req_pend[2] = (w < 2);
      req_data[64 +: 32] = 32'hA0 + w;
      tx_ack = 1'b1;
      #1;
      chk++; if (req_ack !== 4'b0100 || tx_data !== 32'hA0 + w || tx_pend !== (w < 2)) begin err++; $display("FAIL mw_word%0d: got ack=%b data=%h pend=%b", w, req_ack, tx_data, tx_pend); end
      cyc();
      tx_ack = 1'b0;
      cyc();
      chk++; if (grant !== 4'b0100) begin err++; $display("FAIL mw_hold%0d: got %b want 0100", w, grant); end
    end
    req_pend = '0;
    tx_succ = 1'b1;
    cyc();
    tx_succ = 1'b0;
    #1;
    chk++; if (tx_resp_ack !== 1'b1 || req_succ !== 4'b0100 || req_fail !== 4'b0000) begin err++; $display("FAIL mw_resp: got resp_ack=%b succ=%b fail=%b", tx_resp_ack, req_succ, req_fail); end
    cyc();
    cyc();
    chk++; if (tx_resp_ack !== 1'b0 || req_succ !== 4'b0100 || grant !== 4'b0100) begin err++; $display("FAIL mw_resp_hold: got resp_ack=%b succ=%b grant=%b", tx_resp_ack, req_succ, grant); end
    req_req = 4'b0001;
    req_resp_ack = 4'b0100;
    cyc();
    req_resp_ack = '0;
    chk++; if (grant !== 4'b0000) begin err++; $display("FAIL mw_idle_gap: got %b want 0000", grant); end
    cyc();
    chk++; if (grant !== 4'b0001) begin err++; $display("FAIL mw_next_grant: got %b want 0001", grant); end
    finish_msg(4'b0001);
  endtask

  task automatic test_fail;
    req_req = 4'b0010;
    req_pend = 4'b0010;
    cyc();
    tx_ack = 1'b1;
    cyc();
    tx_ack = 1'b0;
    tx_fail = 1'b1;
    cyc();
    tx_fail = 1'b0;
    #1;
    chk++; if (req_fail !== 4'b0010 || req_succ !== 4'b0000 || tx_resp_ack !== 1'b1) begin err++; $display("FAIL underflow: got fail=%b succ=%b resp_ack=%b", req_fail, req_succ, tx_resp_ack); end
    req_pend = '0;
    req_req = '0;
    req_resp_ack = 4'b0010;
    cyc();
    req_resp_ack = '0;
    chk++; if (grant !== 4'b0000 || req_fail !== 4'b0000) begin err++; $display("FAIL fail_release: got grant=%b fail=%b", grant, req_fail); end
    req_req = 4'b0100;
    cyc();
    tx_succ = 1'b1;
    tx_fail = 1'b1;
    cyc();
    tx_succ = 1'b0;
    tx_fail = 1'b0;
    #1;
    chk++; if (req_fail !== 4'b0100 || req_succ !== 4'b0000) begin err++; $display("FAIL both_high: got fail=%b succ=%b want 0100 0000", req_fail, req_succ); end
    req_req = '0;
    req_resp_ack = 4'b0100;
    cyc();
    req_resp_ack = '0;
  endtask

  task automatic test_withdraw;
    req_req = 4'b1000;
    cyc();
    chk++; if (grant !== 4'b1000) begin err++; $display("FAIL wd_grant: got %b want 1000", grant); end
    req_req = '0;
    cyc();
    chk++; if (grant !== 4'b0000 || tx_resp_ack !== 1'b0) begin err++; $display("FAIL wd_release: got grant=%b resp_ack=%b", grant, tx_resp_ack); end
    req_req = 4'b1001;
    cyc();
    chk++; if (grant !== EXP_1001_PTR3) begin err++; $display("FAIL wd_ptr_kept: got %b want %b", grant, EXP_1001_PTR3); end
    finish_msg(grant);
    req_req = '0;
    cyc();
  endtask

  task automatic test_two_msgs;
    req_req = 4'b1001;
    cyc();
    chk++; if (grant !== 4'b0001) begin err++; $display("FAIL two_first: got %b want 0001", grant); end
    finish_msg(4'b0001);
    req_req = 4'b1001;
    cyc();
    chk++; if (grant !== EXP_SECOND) begin err++; $display("FAIL two_second: got %b want %b", grant, EXP_SECOND); end
    finish_msg(grant);
    req_req = '0;
    cyc();
  endtask

  task automatic test_reset_midmsg;
    req_req = 4'b0010;
    cyc();
    finish_msg(4'b0010);
    req_req = 4'b0100;
    cyc();
    tx_ack = 1'b1;
    cyc();
    tx_ack = 1'b0;
    cyc();
    chk++; if (tx_req !== 1'b1 || grant !== 4'b0100) begin err++; $display("FAIL mid_wait: got req=%b grant=%b", tx_req, grant); end
    RESET = 1'b1;
    cyc();
    chk++; if (grant !== 4'b0000 || tx_req !== 1'b0 || tx_resp_ack !== 1'b0 || tx_addr !== 8'h00 || tx_data !== 32'h0) begin err++; $display("FAIL mid_reset_tx: got grant=%b req=%b resp_ack=%b addr=%h data=%h", grant, tx_req, tx_resp_ack, tx_addr, tx_data); end
    chk++; if ({req_ack, req_succ, req_fail} !== 12'h000) begin err++; $display("FAIL mid_reset_req: got %h want 000", {req_ack, req_succ, req_fail}); end
    RESET = 1'b0;
    req_req = 4'b1111;
    cyc();
    chk++; if (grant !== 4'b0001) begin err++; $display("FAIL post_reset_order: got %b want 0001", grant); end
  endtask

  initial begin
    req_addr = 32'h13121110;
    req_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    req_pend = '0;
    req_req = '0;
    req_resp_ack = '0;
    tx_ack = 1'b0;
    tx_succ = 1'b0;
    tx_fail = 1'b0;
    test_reset();
    test_rr_pair();
    test_multiword();
    test_fail();
    test_withdraw();
    test_two_msgs();
    test_reset_midmsg();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
